// File: rtl/conv2d_engine.sv
// conv2d_engine: one-MAC-per-cycle 2D convolution reading pixels and weights from external memories.
// Define CONV2D_ENGINE_RELU_EN to clamp negative results to zero on the output port.
module conv2d_engine #(
    parameter int DATA_WIDTH    = 16,
    parameter int FRACTION_BITS = 8,
    parameter int IN_WIDTH      = 28,
    parameter int IN_HEIGHT     = 28,
    parameter int IN_CHANNEL    = 1,
    parameter int OUT_CHANNEL   = 4,
    parameter int KER_WIDTH     = 3,
    parameter int KER_HEIGHT    = 3,
    parameter int STRIDE        = 1,
    parameter int PAD           = 0,
    parameter int IN_ADR_WIDTH  = 16,
    parameter int OUT_ADR_WIDTH = 16,
    parameter int KER_ADR_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     in_rd,
    output logic [IN_ADR_WIDTH-1:0]  in_adr,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     ker_rd,
    output logic                     ker_wb,
    output logic [KER_ADR_WIDTH-1:0] ker_x,
    output logic [KER_ADR_WIDTH-1:0] ker_y,
    output logic [KER_ADR_WIDTH-1:0] ker_chIn,
    output logic [KER_ADR_WIDTH-1:0] ker_chOut,
    input  logic [DATA_WIDTH-1:0]    ker_data,
    output logic                     out_wr,
    output logic [OUT_ADR_WIDTH-1:0] out_adr,
    output logic [DATA_WIDTH-1:0]    out_data
);

    localparam int OUT_W = (IN_WIDTH + 2 * PAD - KER_WIDTH) / STRIDE + 1;
    localparam int OUT_H = (IN_HEIGHT + 2 * PAD - KER_HEIGHT) / STRIDE + 1;
    localparam int ACC_W = 2 * DATA_WIDTH;

    localparam logic [KER_ADR_WIDTH-1:0] KX_LAST = KER_ADR_WIDTH'(KER_WIDTH - 1);
    localparam logic [KER_ADR_WIDTH-1:0] KY_LAST = KER_ADR_WIDTH'(KER_HEIGHT - 1);
    localparam logic [KER_ADR_WIDTH-1:0] CI_LAST = KER_ADR_WIDTH'(IN_CHANNEL - 1);
    localparam logic [KER_ADR_WIDTH-1:0] CO_LAST = KER_ADR_WIDTH'(OUT_CHANNEL - 1);
    localparam logic [OUT_ADR_WIDTH-1:0] X_LAST  = OUT_ADR_WIDTH'(OUT_W - 1);
    localparam logic [OUT_ADR_WIDTH-1:0] Y_LAST  = OUT_ADR_WIDTH'(OUT_H - 1);

    localparam logic signed [ACC_W:0] SAT_MAX = {{(DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ACC, BIAS, WRITE, DONE} stateT;

    stateT                    state, stateNxt;
    logic [KER_ADR_WIDTH-1:0] kx, ky, chIn, chOut;
    logic [KER_ADR_WIDTH-1:0] kxNxt, kyNxt, chInNxt, chOutNxt;
    logic [OUT_ADR_WIDTH-1:0] outX, outY, outXNxt, outYNxt;

    int                       tapY, tapX;
    logic                     tapInside;
    logic [IN_ADR_WIDTH-1:0]  tapAdr;
    logic [OUT_ADR_WIDTH-1:0] wrAdr;

    logic                     vld_p1;
    logic signed [ACC_W-1:0]  pixExt_p1, kerExt_p1, prodFull_p1, prodScaled_p1;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    biasSum;

    function automatic logic signed [DATA_WIDTH-1:0] satWord(input logic signed [ACC_W:0] v);
        if (v > SAT_MAX) return SAT_MAX[DATA_WIDTH-1:0];
        if (v < SAT_MIN) return SAT_MIN[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] reluWord(input logic signed [DATA_WIDTH-1:0] v);
`ifdef CONV2D_ENGINE_RELU_EN
        return v[DATA_WIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_comb begin
        stateNxt = state;
        kxNxt    = kx;
        kyNxt    = ky;
        chInNxt  = chIn;
        chOutNxt = chOut;
        outXNxt  = outX;
        outYNxt  = outY;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNxt = ACC;
                    kxNxt    = '0;
                    kyNxt    = '0;
                    chInNxt  = '0;
                    chOutNxt = '0;
                    outXNxt  = '0;
                    outYNxt  = '0;
                end
            end
            ACC: begin
                kxNxt = kx + 1'b1;
                if (kx == KX_LAST) begin
                    kxNxt = '0;
                    kyNxt = ky + 1'b1;
                    if (ky == KY_LAST) begin
                        kyNxt   = '0;
                        chInNxt = chIn + 1'b1;
                        if (chIn == CI_LAST) begin
                            chInNxt  = '0;
                            stateNxt = BIAS;
                        end
                    end
                end
            end
            BIAS: stateNxt = WRITE;
            WRITE: begin
                stateNxt = ACC;
                chOutNxt = chOut + 1'b1;
                if (chOut == CO_LAST) begin
                    chOutNxt = '0;
                    outXNxt  = outX + 1'b1;
                    if (outX == X_LAST) begin
                        outXNxt = '0;
                        outYNxt = outY + 1'b1;
                        if (outY == Y_LAST) begin
                            outYNxt  = '0;
                            stateNxt = DONE;
                        end
                    end
                end
            end
            DONE:    stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Addresses are derived from the next-cycle coordinates so the strobes can be registered.
    always_comb begin
        tapY      = int'(outYNxt) * STRIDE + int'(kyNxt) - PAD;
        tapX      = int'(outXNxt) * STRIDE + int'(kxNxt) - PAD;
        tapInside = (tapY >= 0) && (tapY < IN_HEIGHT) && (tapX >= 0) && (tapX < IN_WIDTH);
        tapAdr    = IN_ADR_WIDTH'((tapY * IN_WIDTH + tapX) * IN_CHANNEL + int'(chInNxt));
        wrAdr     = OUT_ADR_WIDTH'((int'(outYNxt) * OUT_W + int'(outXNxt)) * OUT_CHANNEL + int'(chOutNxt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            kx        <= '0;
            ky        <= '0;
            chIn      <= '0;
            chOut     <= '0;
            outX      <= '0;
            outY      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_rd     <= 1'b0;
            in_adr    <= '0;
            ker_rd    <= 1'b0;
            ker_wb    <= 1'b0;
            ker_x     <= '0;
            ker_y     <= '0;
            ker_chIn  <= '0;
            ker_chOut <= '0;
            out_wr    <= 1'b0;
            out_adr   <= '0;
        end else begin
            state     <= stateNxt;
            kx        <= kxNxt;
            ky        <= kyNxt;
            chIn      <= chInNxt;
            chOut     <= chOutNxt;
            outX      <= outXNxt;
            outY      <= outYNxt;
            busy      <= (stateNxt != IDLE);
            done      <= (stateNxt == DONE);
            in_rd     <= (stateNxt == ACC) && tapInside;
            in_adr    <= ((stateNxt == ACC) && tapInside) ? tapAdr : '0;
            ker_rd    <= (stateNxt == ACC) || (stateNxt == BIAS);
            ker_wb    <= (stateNxt == ACC);
            ker_x     <= kxNxt;
            ker_y     <= kyNxt;
            ker_chIn  <= chInNxt;
            ker_chOut <= chOutNxt;
            out_wr    <= (stateNxt == WRITE);
            out_adr   <= wrAdr;
        end
    end

    // p1: memory data returns; padded taps never raised in_rd and so add nothing
    assign pixExt_p1     = {{DATA_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
    assign kerExt_p1     = {{DATA_WIDTH{ker_data[DATA_WIDTH-1]}}, ker_data};
    assign prodFull_p1   = pixExt_p1 * kerExt_p1;
    assign prodScaled_p1 = prodFull_p1 >>> FRACTION_BITS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            acc    <= '0;
        end else begin
            vld_p1 <= in_rd;
            if (state == WRITE) begin
                acc <= '0;
            end else if (vld_p1) begin
                acc <= acc + prodScaled_p1;
            end
        end
    end

    // Bias word arrives during WRITE; the result is combinational off the accumulator.
    assign biasSum  = {acc[ACC_W-1], acc} + {{(DATA_WIDTH + 1){ker_data[DATA_WIDTH-1]}}, ker_data};
    assign out_data = out_wr ? reluWord(satWord(biasSum)) : '0;

endmodule

// File: tb/tb_conv2d_engine.sv
// tb_conv2d_engine: directed checks of conv2d_engine on three small configurations.
// Instance 0: 4x4 PAD0 STRIDE1, instance 1: 4x4 PAD1, instance 2: 5x5 STRIDE2.
module tb_conv2d_engine;

    logic clk;
    logic rst;
    logic [2:0]       start, busy, done, inRd, kerRd, kerWb, outWr;
    logic [2:0][15:0] inAdr, inData, kerData, outAdr, outData;
    logic [2:0][7:0]  kerX, kerY, kerCi, kerCo;

    int pixVal, wVal, bVal;
    int nChecks, nErrors;

    int          wrCnt[3];
    int          rdCnt[3];
    int          tapCnt[3];
    logic [15:0] wrAdr[3][1024];
    logic [15:0] wrDat[3][1024];
    logic [15:0] rdAdr[3][1024];

    conv2d_engine #(.IN_WIDTH(4), .IN_HEIGHT(4), .OUT_CHANNEL(1), .STRIDE(1), .PAD(0)) dutA (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .in_rd(inRd[0]), .in_adr(inAdr[0]), .in_data(inData[0]),
        .ker_rd(kerRd[0]), .ker_wb(kerWb[0]), .ker_x(kerX[0]), .ker_y(kerY[0]),
        .ker_chIn(kerCi[0]), .ker_chOut(kerCo[0]), .ker_data(kerData[0]),
        .out_wr(outWr[0]), .out_adr(outAdr[0]), .out_data(outData[0]));

    conv2d_engine #(.IN_WIDTH(4), .IN_HEIGHT(4), .OUT_CHANNEL(1), .STRIDE(1), .PAD(1)) dutB (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .in_rd(inRd[1]), .in_adr(inAdr[1]), .in_data(inData[1]),
        .ker_rd(kerRd[1]), .ker_wb(kerWb[1]), .ker_x(kerX[1]), .ker_y(kerY[1]),
        .ker_chIn(kerCi[1]), .ker_chOut(kerCo[1]), .ker_data(kerData[1]),
        .out_wr(outWr[1]), .out_adr(outAdr[1]), .out_data(outData[1]));

    conv2d_engine #(.IN_WIDTH(5), .IN_HEIGHT(5), .OUT_CHANNEL(1), .STRIDE(2), .PAD(0)) dutC (
        .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .in_rd(inRd[2]), .in_adr(inAdr[2]), .in_data(inData[2]),
        .ker_rd(kerRd[2]), .ker_wb(kerWb[2]), .ker_x(kerX[2]), .ker_y(kerY[2]),
        .ker_chIn(kerCi[2]), .ker_chOut(kerCo[2]), .ker_data(kerData[2]),
        .out_wr(outWr[2]), .out_adr(outAdr[2]), .out_data(outData[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memories: pixel word is returned every cycle regardless of in_rd; kernel word is registered on ker_rd.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            inData[d] <= 16'(pixVal);
            if (kerRd[d]) kerData[d] <= kerWb[d] ? 16'(wVal) : 16'(bVal);
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (outWr[d] && wrCnt[d] < 1024) begin
                wrAdr[d][wrCnt[d]] = outAdr[d];
                wrDat[d][wrCnt[d]] = outData[d];
                wrCnt[d]++;
            end
            if (inRd[d] && rdCnt[d] < 1024) begin
                rdAdr[d][rdCnt[d]] = inAdr[d];
                rdCnt[d]++;
            end
            if (kerRd[d] && kerWb[d]) tapCnt[d]++;
        end
    end

    task automatic checkVal(input string tag, input longint obs, input longint exp);
        nChecks++;
        if (obs !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle (cycle 0) and count cycles until done; optional stray start at cycle pulseAt.
    task automatic runLayer(input int d, input int pulseAt, input int expLat);
        int lat;
        lat = -1;
        @(negedge clk);
        checkVal("busy_at_start", busy[d], 0);
        start[d] = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            start[d] = (k == pulseAt);
            if (k == 1) checkVal("busy_cycle1", busy[d], 1);
            if (done[d]) begin
                lat = k;
                break;
            end
        end
        checkVal("done_latency", lat, expLat);
    endtask

    initial begin
        int wb, rb;
        int expPad[16];
        int expNeg;
        expPad = '{1152, 1664, 1664, 1152,
                   1664, 2432, 2432, 1664,
                   1664, 2432, 2432, 1664,
                   1152, 1664, 1664, 1152};
`ifdef CONV2D_ENGINE_RELU_EN
        expNeg = 0;
`else
        expNeg = 32'h8000;
`endif
        nChecks = 0;
        nErrors = 0;
        for (int d = 0; d < 3; d++) begin
            wrCnt[d]  = 0;
            rdCnt[d]  = 0;
            tapCnt[d] = 0;
        end
        rst    = 1'b1;
        start  = '0;
        pixVal = 256;
        wVal   = 256;
        bVal   = 128;
        repeat (3) @(negedge clk);

        checkVal("rst_busy", busy[0], 0);
        checkVal("rst_done", done[0], 0);
        checkVal("rst_in_rd", inRd[0], 0);
        checkVal("rst_ker_rd", kerRd[0], 0);
        checkVal("rst_ker_wb", kerWb[0], 0);
        checkVal("rst_out_wr", outWr[0], 0);
        checkVal("rst_in_adr", inAdr[0], 0);
        checkVal("rst_out_adr", outAdr[0], 0);
        checkVal("rst_out_data", outData[0], 0);
        checkVal("rst_ker_coord", {kerX[0], kerY[0], kerCi[0], kerCo[0]}, 0);
        rst = 1'b0;

        // 4x4 ones, 3x3 ones, bias 0.5: four outputs of 9.5
        wb = wrCnt[0];
        runLayer(0, 0, 45);
        checkVal("a_write_count", wrCnt[0] - wb, 4);
        for (int i = 0; i < 4; i++) begin
            checkVal("a_out_adr", wrAdr[0][wb + i], i);
            checkVal("a_out_data", wrDat[0][wb + i], 2432);
        end
        @(negedge clk);
        checkVal("a_idle_busy", busy[0], 0);
        checkVal("a_idle_done", done[0], 0);

        // PAD=1: corners 4.5, edges 6.5, inner 9.5; only 100 of 144 taps read memory
        wb = wrCnt[1];
        runLayer(1, 0, 177);
        checkVal("b_write_count", wrCnt[1] - wb, 16);
        for (int i = 0; i < 16; i++) begin
            checkVal("b_out_adr", wrAdr[1][wb + i], i);
            checkVal("b_out_data", wrDat[1][wb + i], expPad[i]);
        end
        checkVal("b_in_rd_count", rdCnt[1], 100);
        checkVal("b_weight_taps", tapCnt[1], 144);

        // 5x5 STRIDE=2: output (1,1) reads start at address 12
        wb = wrCnt[2];
        runLayer(2, 0, 45);
        checkVal("c_write_count", wrCnt[2] - wb, 4);
        for (int i = 0; i < 4; i++) begin
            checkVal("c_out_adr", wrAdr[2][wb + i], i);
            checkVal("c_out_data", wrDat[2][wb + i], 2432);
        end
        checkVal("c_in_rd_count", rdCnt[2], 36);
        checkVal("c_adr_out01", rdAdr[2][9], 2);
        checkVal("c_adr_out10", rdAdr[2][18], 10);
        checkVal("c_adr_out11_0", rdAdr[2][27], 12);
        checkVal("c_adr_out11_1", rdAdr[2][28], 13);
        checkVal("c_adr_out11_3", rdAdr[2][30], 17);
        checkVal("c_adr_out11_8", rdAdr[2][35], 24);

        // Saturation: +100.0 per tap overflows high, -100.0 overflows low
        pixVal = 2560;
        wVal   = 2560;
        bVal   = 0;
        wb = wrCnt[0];
        runLayer(0, 0, 45);
        for (int i = 0; i < 4; i++) checkVal("sat_pos", wrDat[0][wb + i], 32'h7FFF);
        wVal = -2560;
        wb = wrCnt[0];
        runLayer(0, 0, 45);
        for (int i = 0; i < 4; i++) checkVal("sat_neg", wrDat[0][wb + i], expNeg);

        // Reset in the 5th ACC cycle, then a clean layer
        pixVal = 256;
        wVal   = 256;
        bVal   = 128;
        @(negedge clk);
        start[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start[0] = 1'b0;
        end
        checkVal("pre_rst_in_rd", inRd[0], 1);
        checkVal("pre_rst_in_adr", inAdr[0], 5);
        rst = 1'b1;
        #1;
        checkVal("mid_rst_busy", busy[0], 0);
        checkVal("mid_rst_out_wr", outWr[0], 0);
        checkVal("mid_rst_in_rd", inRd[0], 0);
        checkVal("mid_rst_ker_rd", kerRd[0], 0);
        checkVal("mid_rst_in_adr", inAdr[0], 0);
        checkVal("mid_rst_ker_x", kerX[0], 0);
        @(negedge clk);
        rst = 1'b0;
        wb = wrCnt[0];
        runLayer(0, 0, 45);
        checkVal("post_rst_write_count", wrCnt[0] - wb, 4);
        for (int i = 0; i < 4; i++) begin
            checkVal("post_rst_adr", wrAdr[0][wb + i], i);
            checkVal("post_rst_data", wrDat[0][wb + i], 2432);
        end

        // Stray start pulse mid-layer must change nothing
        wb = wrCnt[0];
        rb = rdCnt[0];
        runLayer(0, 20, 45);
        checkVal("stray_write_count", wrCnt[0] - wb, 4);
        checkVal("stray_read_count", rdCnt[0] - rb, 36);
        for (int i = 0; i < 4; i++) begin
            checkVal("stray_adr", wrAdr[0][wb + i], i);
            checkVal("stray_data", wrDat[0][wb + i], 2432);
        end
        for (int oy = 0; oy < 2; oy++)
            for (int ox = 0; ox < 2; ox++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++)
                        checkVal("stray_in_adr", rdAdr[0][rb + (oy * 2 + ox) * 9 + ky * 3 + kx],
                                 (oy + ky) * 4 + ox + kx);

        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv2d_engine.md
CONV2D_ENGINE -- requirements
Module: conv2d_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: pixel, weight, bias and output word width (two's complement fixed point).
REQ-002 SHALL have parameter FRACTION_BITS, default 8: fraction bits of every data word.
REQ-003 SHALL have parameters IN_WIDTH / IN_HEIGHT, default 28 / 28: input feature-map dimensions.
REQ-004 SHALL have parameters IN_CHANNEL / OUT_CHANNEL, default 1 / 4: input and output channel counts.
REQ-005 SHALL have parameters KER_WIDTH / KER_HEIGHT, default 3 / 3: kernel dimensions.
REQ-006 SHALL have parameter STRIDE, default 1: step in x and y, range 1..KER_WIDTH.
REQ-007 SHALL have parameter PAD, default 0: zero border in x and y, range 0..KER_WIDTH-1.
REQ-008 SHALL have parameters IN_ADR_WIDTH / OUT_ADR_WIDTH / KER_ADR_WIDTH, default 16 / 16 / 8: address widths.
REQ-009 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-010 SHALL have ports: start  in  1  begin a layer; busy  out  1  layer in progress; done  out  1  one-cycle completion pulse.
REQ-011 SHALL have ports: in_rd  out  1  input read strobe; in_adr  out  IN_ADR_WIDTH  input address; in_data  in  DATA_WIDTH  input word, valid one cycle after in_rd.
REQ-012 SHALL have ports: ker_rd  out  1  kernel read strobe; ker_wb  out  1  1=weight, 0=bias; ker_x, ker_y, ker_chIn, ker_chOut  out  KER_ADR_WIDTH each  kernel coordinates; ker_data  in  DATA_WIDTH  valid one cycle after ker_rd.
REQ-013 SHALL have ports: out_wr  out  1  write strobe; out_adr  out  OUT_ADR_WIDTH  output address; out_data  out  DATA_WIDTH  result word.

Function
REQ-014 SHALL compute OUT_W=(IN_WIDTH+2*PAD-KER_WIDTH)/STRIDE+1 and OUT_H likewise from the height parameters.
REQ-015 SHALL produce outputs in order y (outer), x, chOut (inner), accumulating each in order chIn, ky, kx; N=IN_CHANNEL*KER_HEIGHT*KER_WIDTH.
REQ-016 SHALL implement FSM IDLE -> ACC (N cycles) -> BIAS (1) -> WRITE (1) -> ACC for the next output, or -> DONE (1) -> IDLE after the last output.
REQ-017 SHALL leave IDLE on start=1; start SHALL be ignored in every other state.
REQ-018 SHALL, in ACC, assert ker_rd=1, ker_wb=1 and in_rd=1, with in_adr=(iy*IN_WIDTH+ix)*IN_CHANNEL+chIn, where iy=y*STRIDE+ky-PAD and ix=x*STRIDE+kx-PAD.
REQ-019 SHALL, when iy or ix falls outside the input, hold in_rd=0 and use pixel value zero for that tap.
REQ-020 SHALL accumulate each fixed-point product (full product shifted right by FRACTION_BITS) one cycle after its issue, into an accumulator of 2*DATA_WIDTH bits.
REQ-021 SHALL, in BIAS, assert ker_rd=1 and ker_wb=0 with ker_chOut=chOut; the product of the last tap is accumulated in this cycle.
REQ-022 SHALL, in WRITE, assert out_wr=1 with out_adr=(y*OUT_W+x)*OUT_CHANNEL+chOut and out_data=sat(acc+ker_data), then clear the accumulator.
REQ-023 SHALL saturate to the signed DATA_WIDTH range: max 2^(DATA_WIDTH-1)-1, min -2^(DATA_WIDTH-1).
REQ-024 SHALL take a total latency of exactly OUT_H*OUT_W*OUT_CHANNEL*(N+2)+1 cycles from the start cycle to the done pulse.
REQ-025 SHALL hold busy=1 from the cycle after start through the DONE cycle, and done=1 only in DONE.

Reset
REQ-026 SHALL, on rst=1 at any time including mid-layer, immediately force state IDLE, all counters and the accumulator to 0, and busy, done, in_rd, ker_rd, out_wr to 0.
REQ-027 SHALL drive all address/coordinate outputs and out_data to 0 while in reset; ker_wb SHALL be 0.

Configuration
REQ-028 SHALL, with macro CONV2D_ENGINE_RELU_EN defined, replace out_data by 0 whenever the saturated result is negative; without the macro, the signed saturated result SHALL be passed unchanged.

Verification
REQ-029 SHALL test: 4x4x1 input all 1.0 (256), 3x3 kernel all 1.0, bias 0.5, STRIDE=1, PAD=0, OUT_CHANNEL=1 -> four writes at addresses 0..3, each with data 9.5 (2432), done at cycle 4*11+1=45.
REQ-030 SHALL test: same data with PAD=1 -> 16 writes; corner outputs 4.5 (1152), edge outputs 6.5 (1664), inner outputs 9.5 (2432); in_rd=0 on all padded taps.
REQ-031 SHALL test: 5x5 input, STRIDE=2, PAD=0 -> 4 writes; the issued in_adr sequence for output (1,1) starts at 12.
REQ-032 SHALL test: all pixels and weights 10.0, 3x3 kernel -> out_data=0x7FFF; all weights -10.0 -> 0x8000 without the macro, 0x0000 with CONV2D_ENGINE_RELU_EN.
REQ-033 SHALL test: rst=1 during the 5th ACC cycle -> the same cycle busy=0, out_wr=0; a following start produces results identical to a clean run.
REQ-034 SHALL test: start pulsed while busy=1 -> no effect on the address sequence, write count, or done timing.
